fifo_read_ctrl: RTL and testbench

//  Read-side controller for the synchronous FIFO (registered data_out, 1-cycle read latency).

---
 rtl/fifo_read_ctrl.sv | 145 ++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Purpose : read-side controller for a synchronous FIFO with registered data_out; turns
//           fifo_empty/fifo_re/fifo_data into a valid/ready stream through a 2-entry buffer.
// Latency : fifo_re in cycle N -> word captured end of N+1 -> m_valid in N+2; 1 word/clk sustained.
// Backpres: reads are credit-limited so buffered + in-flight words never exceed 2; m_ready=0
//           stalls reads once both slots are committed and holds m_data until accepted.
// Build   : define FIFO_RD_CNT_EN to include the accepted-word counter rd_count.
module fifo_read_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_re,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Buffer: m_data is the head slot, tail_dat the second slot; occ counts valid slots.
  logic [1:0]       occ;
  logic             infl;
  logic [WIDTH-1:0] tail_dat;
  logic             pop;
  logic [2:0]       committed;
  logic             credit_ok;

  assign m_valid   = (occ != 2'd0);
  assign pop       = m_valid && m_ready;
  assign busy      = (state != IDLE) || infl || (occ != 2'd0);

  // Words already owned by the buffer (held or arriving next edge) minus the one leaving now
  // must stay below 2 before another read is allowed.
  assign committed = {1'b0, occ} + {2'b00, infl};
  assign credit_ok = committed < (3'd2 + {2'b00, pop});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and FIFO read enable; en gates reads so the cycle en drops issues none.
  always_comb begin
    state_nxt = state;
    fifo_re   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = DRAIN;
        end else begin
          fifo_re = !fifo_empty && credit_ok;
        end
      end
      DRAIN: begin
        if (en) begin
          state_nxt = RUN;
        end else if (!infl && (occ == 2'd0)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // In-flight flag and 2-entry buffer: capture the word read last cycle, advance on pop,
  // keep FIFO order. m_data is left untouched when the last word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl     <= 1'b0;
      occ      <= 2'd0;
      m_data   <= '0;
      tail_dat <= '0;
    end else begin
      infl <= fifo_re;
      case ({infl, pop})
        2'b01: begin
          if (occ == 2'd2) begin
            m_data <= tail_dat;
          end
          occ <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            m_data <= fifo_data;
          end else begin
            tail_dat <= fifo_data;
          end
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            m_data   <= tail_dat;
            tail_dat <= fifo_data;
          end else begin
            m_data <= fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rd_count = cnt;
`else
  assign rd_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Purpose : directed bench for fifo_read_ctrl with a behavioural FIFO and a word scoreboard.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpres: m_ready is driven per step; every wait on the DUT has a cycle budget.
module tb_fifo_read_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_re;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             busy;
  logic [CNT_W-1:0] rd_count;

  fifo_read_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .rd_count   (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered data_out valid the cycle after the read.
  logic [WIDTH-1:0] mem [0:63];
  logic [5:0]       wr_ptr;
  logic [5:0]       rd_ptr;
  logic             flush;

  assign fifo_empty = (wr_ptr == rd_ptr);

  initial begin
    rd_ptr    = 6'd0;
    fifo_data = '0;
  end

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_re && (rd_ptr != wr_ptr)) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  logic [WIDTH-1:0] exp_q[$];
  int n_assert;
  int n_fail;
  int cyc_n;
  int nre;
  int acc;
  int first_re;
  int first_vld;
  int last_acc;
  int nre_stop;
  int budget;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rc(input int n);
`ifdef FIFO_RD_CNT_EN
    return n % (1 << CNT_W);
`else
    return (n > n) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic push(input logic [WIDTH-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 6'd1;
    exp_q.push_back(v);
  endtask

  task automatic clr();
    nre       = 0;
    acc       = 0;
    first_re  = -1;
    first_vld = -1;
    last_acc  = -1;
  endtask

  // One clock: sample outputs mid-cycle, score acceptances, then advance past the edge.
  task automatic cyc();
    logic [WIDTH-1:0] e;
    #1;
    cyc_n++;
    if (!rst) begin
      chk("no_underflow_read", {31'd0, fifo_re && fifo_empty}, 32'd0);
      if (fifo_re) begin
        nre++;
        if (first_re < 0) first_re = cyc_n;
      end
      if (m_valid && first_vld < 0) first_vld = cyc_n;
      if (m_valid && m_ready) begin
        acc++;
        last_acc = cyc_n;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_order", {16'd0, m_data}, {16'd0, e});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_acc(input string tag, input int target, input int lim);
    budget = lim;
    while (acc < target && budget > 0) begin
      cyc();
      budget--;
    end
    chk(tag, acc, target);
  endtask

  task automatic wait_idle(input string tag);
    en     = 1'b0;
    budget = 30;
    while (busy && budget > 0) begin
      cyc();
      budget--;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    en    = 1'b0;
    flush = 1'b1;
    cyc();
    cyc();
    rst   = 1'b0;
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc_n    = 0;
    wr_ptr   = 6'd0;
    rst      = 1'b1;
    en       = 1'b0;
    m_ready  = 1'b0;
    flush    = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // Reset values.
    do_reset();
    chk("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_count", {28'd0, rd_count}, 32'd0);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) push(i[WIDTH-1:0]);
    clr();
    en      = 1'b1;
    m_ready = 1'b1;
    wait_acc("stream_count", 8, 40);
    chk("stream_latency", first_vld - first_re, 2);
    chk("stream_back_to_back", last_acc - first_vld, 7);
    wait_idle("stream_idle");
    chk("stream_reads", nre, 8);
    chk("stream_rd_count", {28'd0, rd_count}, exp_rc(8));

    // Backpressure: only two reads may be outstanding while m_ready is low.
    for (int i = 1; i <= 4; i++) push(i[WIDTH-1:0]);
    clr();
    m_ready = 1'b0;
    en      = 1'b1;
    run(11);
    chk("bp_reads", nre, 2);
    chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_m_data_held", {16'd0, m_data}, 32'd1);
    chk("bp_fifo_re_low", {31'd0, fifo_re}, 32'd0);
    m_ready = 1'b1;
    wait_acc("bp_release_count", 4, 20);
    wait_idle("bp_idle");
    chk("bp_total_reads", nre, 4);

    // Single word: one read pulse, no read while empty.
    push(16'd7);
    clr();
    en = 1'b1;
    wait_acc("single_count", 1, 20);
    run(5);
    chk("single_reads", nre, 1);
    chk("single_m_data_kept", {16'd0, m_data}, 32'd7);
    chk("single_m_valid_low", {31'd0, m_valid}, 32'd0);
    wait_idle("single_idle");

    // Stop/drain mid-stream, then resume.
    for (int i = 1; i <= 8; i++) push(i[WIDTH-1:0]);
    clr();
    en = 1'b1;
    run(4);
    en = 1'b0;
    #1;
    chk("drain_no_re_en_low", {31'd0, fifo_re}, 32'd0);
    cyc();
    nre_stop = nre;
    wait_idle("drain_busy_falls");
    chk("drain_no_new_reads", nre, nre_stop);
    chk("drain_held_delivered", acc, nre_stop);
    chk("drain_fifo_retains", {26'd0, wr_ptr - rd_ptr}, 8 - nre_stop);
    en = 1'b1;
    wait_acc("resume_count", 8, 40);
    wait_idle("resume_idle");

    // Reset in the middle of a stream.
    for (int i = 1; i <= 8; i++) push(i[WIDTH-1:0]);
    clr();
    en     = 1'b1;
    budget = 30;
    while (acc < 3 && budget > 0) begin
      cyc();
      budget--;
    end
    chk("midrst_reach_word3", acc, 3);
    rst   = 1'b1;
    flush = 1'b1;
    cyc();
    rst   = 1'b0;
    flush = 1'b0;
    en    = 1'b0;
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_rd_count", {28'd0, rd_count}, 32'd0);
    chk("midrst_m_data", {16'd0, m_data}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();

    // Counter wrap: 17 accepted words on a 4-bit counter.
    for (int i = 0; i < 17; i++) push(16'h0100 + i[WIDTH-1:0]);
    clr();
    en = 1'b1;
    wait_acc("wrap_count", 17, 80);
    wait_idle("wrap_idle");
    chk("wrap_rd_count", {28'd0, rd_count}, exp_rc(17));
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
